// File: rtl/sdffr_led_bank.sv
// sdffr_led_bank: a bank of scan flip-flops with parallel load, where each bit
// also drives a status LED. An LED can show the bit's level or recent toggle
// activity (stretched so short pulses stay visible), and a shared PWM dims
// every LED.
module sdffr_led_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      STRETCH_CNT = 15,
  parameter int unsigned      PWM_W       = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scan_en_i,
  input  logic             scan_d_i,
  input  logic             load_en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             scan_q_o,
  input  logic             led_mode_i,
  input  logic [PWM_W-1:0] led_duty_i,
  output logic [WIDTH-1:0] led_o
);

  localparam int unsigned          STRETCH_W    = $clog2(STRETCH_CNT + 1);
  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CNT);
  localparam logic [STRETCH_W-1:0] STRETCH_ONE  = STRETCH_W'(1);
  localparam logic [PWM_W-1:0]     DUTY_FULL    = '1;
  localparam logic [PWM_W-1:0]     PWM_ONE      = PWM_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] prev_q_q;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] led_q, led_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             pwm_on;

  // Register next value: shifting beats loading, otherwise the bits hold.
  // The shift is written as a left shift with the serial bit ORed into bit 0,
  // which also covers a single-bit bank.
  always_comb begin
    q_d = q_q;
    if (scan_en_i) begin
      q_d = (q_q << 1) | WIDTH'(scan_d_i);
    end else if (load_en_i) begin
      q_d = d_i;
    end
  end

  assign toggle = q_q ^ prev_q_q;

  // One stretch counter per bit: a toggle (re)loads it, then it counts down
  // to zero and stays there; a bit is "active" while its counter is nonzero.
  for (genvar g = 0; g < WIDTH; g++) begin : g_stretch
    logic [STRETCH_W-1:0] cnt_q, cnt_d;

    // Counter next value: reload on toggle, otherwise count down toward zero.
    always_comb begin
      cnt_d = cnt_q;
      if (toggle[g]) begin
        cnt_d = STRETCH_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - STRETCH_ONE;
      end
    end

    // Counter state, cleared by reset so no activity survives it.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign act[g] = (cnt_q != '0);
  end

  // PWM gate: a full-scale duty forces the LEDs on, otherwise they are lit
  // while the free-running counter is below the duty value.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    pwm_on    = (led_duty_i == DUTY_FULL) || (pwm_cnt_q < led_duty_i);
    led_d     = (led_mode_i ? act : q_q) & {WIDTH{pwm_on}};
  end

  // Main state: register bits, previous-cycle copy, PWM counter, LED drive.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q       <= RESET_VAL;
      prev_q_q  <= RESET_VAL;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      q_q       <= q_d;
      prev_q_q  <= q_q;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign q_o      = q_q;
  assign scan_q_o = q_q[WIDTH-1];
  assign led_o    = led_q;

endmodule

// File: tb/tb_sdffr_led_bank.sv
// Testbench for sdffr_led_bank: the driver applies one input set per clock
// and pushes the expected outputs for that edge onto a scoreboard; a monitor
// on the falling edge pops and compares. Expected LED values come from the
// register history: an activity LED is lit after edge k when its bit changed
// at some edge in [k-STRETCH-1, k-2].
module tb_sdffr_led_bank;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;
  localparam int         S  = 5;
  localparam int         PW = 3;

  logic       clk, rst, scan_en, scan_d, load_en, mode;
  logic [7:0] d;
  logic [2:0] duty;
  logic [7:0] q, led;
  logic       scanq;

  typedef struct {
    logic [7:0] q;
    logic       scanq;
    logic [7:0] led;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon;
  logic [7:0] qHist[$];
  int         edgeIdx;
  int         checks = 0;
  int         errors = 0;
  logic       scanBits[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  sdffr_led_bank #(
    .WIDTH(W), .RESET_VAL(RV), .STRETCH_CNT(S), .PWM_W(PW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .scan_en_i(scan_en), .scan_d_i(scan_d),
    .load_en_i(load_en), .d_i(d), .q_o(q), .scan_q_o(scanq),
    .led_mode_i(mode), .led_duty_i(duty), .led_o(led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    qHist.delete();
    qHist.push_back(RV);
    edgeIdx = 0;
  endtask

  // Drive one cycle's inputs, let the edge happen, then predict outputs.
  task automatic applyStimulus(input logic se, input logic sd, input logic le,
                               input logic [7:0] dv, input logic md,
                               input logic [2:0] dt);
    logic [7:0] cur, act, ledExp, qNew;
    logic       pwmOn;
    int         lo;
    scan_en = se; scan_d = sd; load_en = le; d = dv; mode = md; duty = dt;
    @(posedge clk);
    edgeIdx++;
    cur = qHist[edgeIdx-1];
    act = 8'h00;
    lo  = edgeIdx - S - 1;
    if (lo < 1) lo = 1;
    for (int j = lo; j <= edgeIdx - 2; j++) act |= qHist[j] ^ qHist[j-1];
    pwmOn  = (dt == 3'h7) || (((edgeIdx - 1) % 8) < int'(dt));
    ledExp = pwmOn ? (md ? act : cur) : 8'h00;
    if (se)      qNew = {cur[6:0], sd};
    else if (le) qNew = dv;
    else         qNew = cur;
    qHist.push_back(qNew);
    sb.push_back('{qNew, qNew[7], ledExp});
    @(negedge clk);
  endtask

  // Asynchronous reset between edges, checked before any clock edge.
  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_q", q, RV);
    checkOutput("reset_scan", {7'b0, scanq}, {7'b0, RV[7]});
    checkOutput("reset_led", led, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_q", q, RV);
    checkOutput("reset_hold_led", led, 8'h00);
    @(negedge clk);
    #1 rst = 1'b0;
    modelReset();
  endtask

  // Monitor: every cycle the DUT presents q/scan/led; compare with the queue.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon = sb.pop_front();
      checkOutput("q_o", q, mon.q);
      checkOutput("scan_q_o", {7'b0, scanq}, {7'b0, mon.scanq});
      checkOutput("led_o", led, mon.led);
    end
  end

  initial begin
    rst = 1'b0; scan_en = 1'b0; scan_d = 1'b0; load_en = 1'b0;
    d = 8'h00; mode = 1'b0; duty = 3'h0;
    modelReset();
    doReset();

    // Shift with load also requested: load must be ignored.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, scanBits[i], 1'b1, 8'hFF, 1'b0, 3'h7);

    // Load then hold, level mode at full brightness.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 3'h7);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'h7);

    // Activity mode: flip bit 2, then flip it back mid-pulse.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h38, 1'b1, 3'h7);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'h7);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 3'h7);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'h7);

    // PWM dimming on a single lit bit.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 3'h3);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'h3);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'h0);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'h7);

    // Reset mid-stretch: counter at 3, PWM counter at 5 when reset hits.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'h7);
    applyStimulus(1'b0, 1'b0, 1'b1, RV ^ 8'h04, 1'b1, 3'h7);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'h7);
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'h7);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'h3);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) doReset();
      applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                    8'($urandom), 1'($urandom), 3'($urandom));
    end

    #1;
    checkOutput("scoreboard_drain", 8'(sb.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
